alu_control_mdu: RTL and testbench

Execute-stage operation decoder with an integrated iterative multiply/divide unit (RV32M/RV64M). It decodes the 2-bit instruction-class code plus func3/func7 into the 4-bit ALU opcode for base-ISA operations. It also runs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU as a multi-cycle FSM, stalling the pipeline until the result is ready. It sits between the ID/EX register and the ALU/writeback mux.

---
 rtl/alu_control_mdu.sv | 170 +++++++++++++++++
 tb/tb_alu_control_mdu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu.sv
// Execute-stage decoder: maps instruction class + func3/func7 to the base ALU opcode and
// runs RV M-extension ops on an iterative radix-2 multiply/divide engine that stalls the pipe.
module alu_control_mdu #(
    parameter int XLEN       = 32,
    parameter bit MDU_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      aluControl,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic            inValid,
    input  logic            flush,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    output logic [3:0]      aluControlOut,
    output logic            isMdu,
    output logic            mduStall,
    output logic            mduValid,
    output logic [XLEN-1:0] mduResult
);

    localparam logic [1:0] LOAD_STORE = 2'b00;
    localparam logic [1:0] B_TYPE     = 2'b01;
    localparam logic [1:0] R_TYPE     = 2'b10;
    localparam logic [1:0] I_TYPE     = 2'b11;
    localparam int         CW         = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, next_state;
    logic [2:0]      op;
    logic            sign_a, sign_b;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc_hi, acc_lo, addend;

    logic            start, last_step, a_signed, b_signed, in_sign_a, in_sign_b;
    logic [XLEN-1:0] mag_a, mag_b, special_result, final_result;
    logic            div_by_zero, overflow, special;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] next_hi, next_lo;
    logic [2*XLEN-1:0] product, product_fix;

    assign isMdu     = MDU_ENABLE && (aluControl == R_TYPE) && (func7 == 7'b0000001);
    assign start     = (state == IDLE) && inValid && isMdu && !flush;
    assign last_step = (count == CW'(XLEN - 1));

    // Operand preparation at accept time: signedness per func3, magnitudes, and special cases.
    assign a_signed    = !func3[0] || (func3 == 3'b001);
    assign b_signed    = (func3 == 3'b000) || (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    assign in_sign_a   = a_signed && operandA[XLEN-1];
    assign in_sign_b   = b_signed && operandB[XLEN-1];
    assign mag_a       = in_sign_a ? -operandA : operandA;
    assign mag_b       = in_sign_b ? -operandB : operandB;
    assign div_by_zero = (operandB == '0);
    assign overflow    = ((func3 == 3'b100) || (func3 == 3'b110)) &&
                         (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
    assign special     = func3[2] && (div_by_zero || overflow);

    always_comb begin
        special_result = '0;
        if (div_by_zero)
            special_result = func3[1] ? operandA : '1;
        else
            special_result = func3[1] ? '0 : operandA;
    end

    // One iteration: shift-add multiply on {acc_hi,acc_lo}, or restoring divide (rem in hi, quotient in lo).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, addend} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, addend};
        if (op[2]) begin
            next_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            next_lo = {acc_lo[XLEN-2:0], !div_diff[XLEN]};
        end else begin
            next_hi = mul_sum[XLEN:1];
            next_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    always_comb begin
        product      = {next_hi, next_lo};
        product_fix  = (sign_a ^ sign_b) ? -product : product;
        final_result = '0;
        case (op)
            3'b000:         final_result = product_fix[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         final_result = product_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: final_result = (sign_a ^ sign_b) ? -next_lo : next_lo;
            default:        final_result = sign_a ? -next_hi : next_hi;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = special ? DONE : CALC;
            CALC:    if (flush) next_state = IDLE;
                     else if (last_step) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mduStall      = start || (state == CALC);
        aluControlOut = 4'b0000;
        if (!isMdu) begin
            case (aluControl)
                LOAD_STORE: aluControlOut = 4'b0010;
                B_TYPE:     aluControlOut = 4'b0110;
                R_TYPE, I_TYPE: begin
                    case (func3)
                        3'b000:  aluControlOut = (aluControl == R_TYPE && func7 == 7'b0100000) ? 4'b0110 : 4'b0010;
                        3'b111:  aluControlOut = 4'b0000;
                        3'b110:  aluControlOut = 4'b0001;
                        3'b100:  aluControlOut = 4'b1000;
                        3'b001:  aluControlOut = 4'b1001;
                        3'b101:  aluControlOut = (func7 == 7'b0100000) ? 4'b1011 : 4'b1010;
                        3'b010:  aluControlOut = 4'b0111;
                        3'b011:  aluControlOut = 4'b1100;
                        default: aluControlOut = 4'b0000;
                    endcase
                end
                default:    aluControlOut = 4'b0000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op        <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            addend    <= '0;
            mduValid  <= 1'b0;
            mduResult <= '0;
        end else begin
            mduValid <= (next_state == DONE);
            if (start) begin
                op     <= func3;
                sign_a <= in_sign_a;
                sign_b <= in_sign_b;
                count  <= '0;
                acc_hi <= '0;
                acc_lo <= func3[2] ? mag_a : mag_b;
                addend <= func3[2] ? mag_b : mag_a;
                if (special)
                    mduResult <= special_result;
            end else if (state == CALC && !flush) begin
                acc_hi <= next_hi;
                acc_lo <= next_lo;
                count  <= count + 1'b1;
                if (last_step)
                    mduResult <= final_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: base decode, every M op, special cases,
// flush, asynchronous reset mid-operation and an M-less build.
module tb_alu_control_mdu;

    localparam int         XLEN       = 32;
    localparam logic [1:0] LOAD_STORE = 2'b00;
    localparam logic [1:0] B_TYPE     = 2'b01;
    localparam logic [1:0] R_TYPE     = 2'b10;
    localparam logic [1:0] I_TYPE     = 2'b11;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      aluControl;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic            inValid, flush;
    logic [XLEN-1:0] operandA, operandB;
    logic [3:0]      aluControlOut, nomduAluOut;
    logic            isMdu, mduStall, mduValid;
    logic            nomduIsMdu, nomduStall, nomduValid;
    logic [XLEN-1:0] mduResult, nomduResult;

    int checks   = 0;
    int failures = 0;

    alu_control_mdu #(.XLEN(XLEN), .MDU_ENABLE(1'b1)) dut (
        .clk(clk), .reset(reset), .aluControl(aluControl), .func3(func3), .func7(func7),
        .inValid(inValid), .flush(flush), .operandA(operandA), .operandB(operandB),
        .aluControlOut(aluControlOut), .isMdu(isMdu), .mduStall(mduStall),
        .mduValid(mduValid), .mduResult(mduResult)
    );

    alu_control_mdu #(.XLEN(XLEN), .MDU_ENABLE(1'b0)) dut_nomdu (
        .clk(clk), .reset(reset), .aluControl(aluControl), .func3(func3), .func7(func7),
        .inValid(inValid), .flush(flush), .operandA(operandA), .operandB(operandB),
        .aluControlOut(nomduAluOut), .isMdu(nomduIsMdu), .mduStall(nomduStall),
        .mduValid(nomduValid), .mduResult(nomduResult)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDecode(input string tag, input logic [1:0] cls, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [3:0] expOut, input logic expMdu);
        @(negedge clk);
        aluControl = cls;
        func3      = f3;
        func7      = f7;
        inValid    = 1'b0;
        #1;
        checkOutput({tag, " aluOut"}, 64'(aluControlOut), 64'(expOut));
        checkOutput({tag, " isMdu"}, 64'(isMdu), 64'(expMdu));
    endtask

    // Issues one M op for a single cycle, then watches stall, valid pulse count, latency and result.
    task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b, input logic [XLEN-1:0] expected, input bit special);
        int              stalls = 0;
        int              pulses = 0;
        int              latency = -1;
        int              expLatency;
        logic [XLEN-1:0] result = '0;
        expLatency = special ? 1 : XLEN + 1;
        @(negedge clk);
        aluControl = R_TYPE;
        func7      = 7'b0000001;
        func3      = f3;
        operandA   = a;
        operandB   = b;
        inValid    = 1'b1;
        #1;
        if (mduStall) stalls++;
        @(posedge clk);
        for (int cyc = 0; cyc < XLEN + 8; cyc++) begin
            @(negedge clk);
            inValid = 1'b0;
            #1;
            if (mduStall) stalls++;
            if (mduValid) begin
                pulses++;
                if (pulses == 1) begin
                    result  = mduResult;
                    latency = cyc + 1;
                end
            end
        end
        checkOutput({tag, " result"}, 64'(result), 64'(expected));
        checkOutput({tag, " latency"}, 64'(latency), 64'(expLatency));
        checkOutput({tag, " stall"}, 64'(stalls), 64'(expLatency));
        checkOutput({tag, " pulses"}, 64'(pulses), 64'd1);
    endtask

    initial begin
        int pulses;
        reset      = 1'b1;
        aluControl = LOAD_STORE;
        func3      = 3'b000;
        func7      = 7'b0000000;
        inValid    = 1'b0;
        flush      = 1'b0;
        operandA   = '0;
        operandB   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset valid", 64'(mduValid), 64'd0);
        checkOutput("reset result", 64'(mduResult), 64'd0);
        checkOutput("reset stall", 64'(mduStall), 64'd0);
        reset = 1'b0;

        checkDecode("R sub",  R_TYPE, 3'b000, 7'b0100000, 4'b0110, 1'b0);
        checkDecode("R sltu", R_TYPE, 3'b011, 7'b0000000, 4'b1100, 1'b0);
        checkDecode("I sra",  I_TYPE, 3'b101, 7'b0100000, 4'b1011, 1'b0);
        checkDecode("I addi", I_TYPE, 3'b000, 7'b0100000, 4'b0010, 1'b0);
        checkDecode("R srl",  R_TYPE, 3'b101, 7'b0000000, 4'b1010, 1'b0);
        checkDecode("R or",   R_TYPE, 3'b110, 7'b0000000, 4'b0001, 1'b0);
        checkDecode("B type", B_TYPE, 3'b000, 7'b0000000, 4'b0110, 1'b0);
        checkDecode("LS",     LOAD_STORE, 3'b010, 7'b0000000, 4'b0010, 1'b0);
        checkDecode("M dec",  R_TYPE, 3'b000, 7'b0000001, 4'b0000, 1'b1);

        applyStimulus("MUL",    3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        applyStimulus("MUL2",   3'b000, 32'h12345678,  32'h00000010, 32'h23456780, 1'b0);
        applyStimulus("MULH",   3'b001, 32'h80000000,  32'h80000000, 32'h40000000, 1'b0);
        applyStimulus("MULHU",  3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        applyStimulus("MULHSU", 3'b010, 32'hFFFFFFFF,  32'd2,        32'hFFFFFFFF, 1'b0);
        applyStimulus("DIV",    3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 1'b0);
        applyStimulus("REM",    3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 1'b0);
        applyStimulus("DIVU",   3'b101, 32'd100,       32'd7,        32'd14,       1'b0);
        applyStimulus("DIVU0",  3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1);
        applyStimulus("REM0",   3'b110, 32'd5,         32'd0,        32'd5,        1'b1);
        applyStimulus("DIVOVF", 3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1'b1);
        applyStimulus("REMOVF", 3'b110, 32'h80000000,  32'hFFFFFFFF, 32'd0,        1'b1);
        applyStimulus("REMU",   3'b111, 32'd100,       32'd7,        32'd2,        1'b0);

        // Flush during the tenth CALC cycle: the op dies and the previous result stays.
        @(negedge clk);
        aluControl = R_TYPE;
        func7      = 7'b0000001;
        func3      = 3'b101;
        operandA   = 32'd100;
        operandB   = 32'd7;
        inValid    = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flush calc stall", 64'(mduStall), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush idle stall", 64'(mduStall), 64'd0);
        pulses = 0;
        for (int cyc = 0; cyc < XLEN + 4; cyc++) begin
            @(negedge clk);
            #1;
            if (mduValid) pulses++;
        end
        checkOutput("flush pulses", 64'(pulses), 64'd0);
        checkOutput("flush held", 64'(mduResult), 64'd2);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        func3    = 3'b000;
        operandA = 32'd7;
        operandB = 32'hFFFFFFFD;
        inValid  = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst valid", 64'(mduValid), 64'd0);
        checkOutput("rst result", 64'(mduResult), 64'd0);
        checkOutput("rst stall", 64'(mduStall), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < XLEN + 4; cyc++) begin
            @(negedge clk);
            #1;
            if (mduValid) pulses++;
        end
        checkOutput("rst pulses", 64'(pulses), 64'd0);
        applyStimulus("DIVU after rst", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);

        // Build without the M extension treats the op as a plain ADD.
        @(negedge clk);
        aluControl = R_TYPE;
        func7      = 7'b0000001;
        func3      = 3'b000;
        operandA   = 32'd3;
        operandB   = 32'd4;
        inValid    = 1'b1;
        #1;
        checkOutput("nomdu isMdu", 64'(nomduIsMdu), 64'd0);
        checkOutput("nomdu stall", 64'(nomduStall), 64'd0);
        checkOutput("nomdu aluOut", 64'(nomduAluOut), 64'(4'b0010));
        @(negedge clk);
        inValid = 1'b0;
        pulses  = 0;
        for (int cyc = 0; cyc < XLEN + 4; cyc++) begin
            @(negedge clk);
            #1;
            if (nomduValid || nomduStall) pulses++;
        end
        checkOutput("nomdu activity", 64'(pulses), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
